speed_scheduler: RTL and testbench
==================================

SPEED_SCHEDULER -- requirements
Module: speed_scheduler

Interface
REQ-001 SHALL have parameter SEC_DIV, default 100000000: clk cycles per game second.
REQ-002 SHALL have parameter TICK_BASE, default 1000000: game-tick period in cycles at sec=0.
REQ-003 SHALL have parameter TICK_STEP, default 5000: period reduction per elapsed second.
REQ-004 SHALL have parameter TICK_MIN, default 100000: period floor in cycles.
REQ-005 SHALL have port clk  input  1  single system clock, all logic on posedge.
REQ-006 SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-007 SHALL have port start  input  1  one-cycle request to begin or restart a game.
REQ-008 SHALL have port pause  input  1  one-cycle request to toggle between RUN and PAUSE.
REQ-009 SHALL have port game_over  input  1  one-cycle request to end the game.
REQ-010 SHALL have port state  output  2  IDLE=0, RUN=1, PAUSE=2, OVER=3.
REQ-011 SHALL have port sec  output  11  elapsed RUN seconds.
REQ-012 SHALL have port sec_tick  output  1  one-cycle pulse when sec increments.
REQ-013 SHALL have port game_tick  output  1  one-cycle pulse per game-tick period.
REQ-014 SHALL have port period  output  32  game-tick period currently in use.

Function
REQ-015 SHALL implement FSM: IDLE -start-> RUN; RUN -pause-> PAUSE; PAUSE -pause-> RUN; RUN or PAUSE -game_over-> OVER; OVER -start-> RUN; all other inputs hold state.
REQ-016 SHALL prioritise simultaneous requests as game_over > pause > start.
REQ-017 SHALL clear the second counter, the tick counter and sec, and load period from sec=0, on every transition into RUN from IDLE or OVER.
REQ-018 SHALL count the second counter 0..SEC_DIV-1 in RUN only, then wrap to 0; sec_tick SHALL pulse in the wrap cycle, with sec incremented on the same edge.
REQ-019 SHALL saturate sec at 2047; at saturation the second counter keeps counting but sec_tick is not asserted.
REQ-020 SHALL compute target = TICK_BASE - TICK_STEP*sec in 32-bit unsigned arithmetic, clamped to TICK_MIN whenever TICK_STEP*sec >= TICK_BASE-TICK_MIN.
REQ-021 SHALL count the tick counter 0..period-1 in RUN only; game_tick SHALL pulse in the period-1 cycle; the counter then wraps to 0 and period loads target on the same edge.
REQ-022 SHALL never change period mid-tick; a sec change affects only the next tick.
REQ-023 SHALL freeze both counters, sec and period in PAUSE and OVER; resuming from PAUSE continues from the frozen counts.
REQ-024 SHALL assert sec_tick and game_tick only in RUN, and SHALL allow both in the same cycle.
REQ-025 SHALL register all outputs, with no combinational path from inputs to outputs.

Reset
REQ-026 SHALL, while rst=0, force state=IDLE, sec=0, sec_tick=0, game_tick=0, period=TICK_BASE and both counters to 0, independent of clk.
REQ-027 SHALL resume in IDLE on the first clk edge after rst deasserts, including when reset is taken mid-RUN or mid-PAUSE.

Configuration
REQ-028 SHALL, with SPEEDUP_EN defined, compute period per REQ-020; with it undefined, period SHALL remain TICK_BASE at all times and the multiplier SHALL not be synthesised.

Verification (SEC_DIV=100, TICK_BASE=40, TICK_STEP=5, TICK_MIN=10, SPEEDUP_EN defined unless stated)
REQ-029 SHALL cover reset: rst=0 mid-RUN -> state=0, sec=0, period=40, no pulses, asynchronously before the next clk edge.
REQ-030 SHALL cover start: start pulse -> state=1 next cycle; first game_tick 40 cycles and first sec_tick 100 cycles after entering RUN, with sec=1.
REQ-031 SHALL cover speedup: after sec reaches 6, the following tick period is 10; at sec=7 and sec=20 it stays 10 (clamp).
REQ-032 SHALL cover pause: pause at tick count 25 -> no pulses for 500 cycles; second pause -> next game_tick after the remaining 15 cycles.
REQ-033 SHALL cover priority: game_over and pause in the same cycle in RUN -> state=3, no pulses; then start -> state=1, sec=0, period=40.
REQ-034 SHALL cover the macro: SPEEDUP_EN undefined -> period=40 at sec=0 and at sec=10; game_tick every 40 cycles.

Source files
------------

// File: rtl/speed_scheduler.sv
// -----------------------------------------------------------------------------
// speed_scheduler
//
// Game-flow controller. A four-state FSM (IDLE, RUN, PAUSE, OVER) gates a
// seconds counter and a game-tick counter. The game-tick period shrinks as
// elapsed seconds grow, down to a floor, so the game speeds up over time.
//
// Optional feature macro:
//   SPEEDUP_EN  - when defined, the tick period follows
//                 TICK_BASE - TICK_STEP*sec, clamped to TICK_MIN.
//                 When undefined, the period stays at TICK_BASE and no
//                 multiplier is built.
//
// Parameters:
//   SEC_DIV    clk cycles per game second
//   TICK_BASE  game-tick period in cycles at sec = 0
//   TICK_STEP  period reduction per elapsed second
//   TICK_MIN   period floor in cycles
//
// Ports:
//   clk        system clock, all logic on posedge
//   rst        asynchronous active-low reset
//   start      one-cycle request: begin / restart a game (IDLE or OVER -> RUN)
//   pause      one-cycle request: toggle RUN <-> PAUSE
//   game_over  one-cycle request: RUN or PAUSE -> OVER
//   state      current state: IDLE=0, RUN=1, PAUSE=2, OVER=3
//   sec        elapsed RUN seconds, saturating at 2047
//   sec_tick   one-cycle pulse when sec increments
//   game_tick  one-cycle pulse per game-tick period
//   period     game-tick period currently in use
//
// Request priority when several arrive together: game_over > pause > start.
// Both pulses are registered on the edge where their counter wraps, so they
// are visible in the cycle after the last count of the period.
// -----------------------------------------------------------------------------
module speed_scheduler #(
    parameter int SEC_DIV   = 100000000,
    parameter int TICK_BASE = 1000000,
    parameter int TICK_STEP = 5000,
    parameter int TICK_MIN  = 100000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        pause,
    input  logic        game_over,
    output logic [1:0]  state,
    output logic [10:0] sec,
    output logic        sec_tick,
    output logic        game_tick,
    output logic [31:0] period
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2,
        ST_OVER  = 2'd3
    } state_t;

    localparam logic [31:0] SEC_LAST = 32'(SEC_DIV - 1);
    localparam logic [31:0] BASE     = 32'(TICK_BASE);
    localparam logic [10:0] SEC_MAX  = 11'd2047;

    state_t      state_q;
    state_t      state_d;
    logic [31:0] sec_cnt_q;
    logic [31:0] tick_cnt_q;
    logic [10:0] sec_q;
    logic [31:0] period_q;
    logic        sec_tick_q;
    logic        game_tick_q;

    logic        restart;
    logic        advance;
    logic        sec_wrap;
    logic        tick_wrap;
    logic [31:0] target;

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can
        // leave it unassigned and infer a latch.
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (start) state_d = ST_RUN;
            end
            ST_RUN: begin
                if (game_over)  state_d = ST_OVER;
                else if (pause) state_d = ST_PAUSE;
            end
            ST_PAUSE: begin
                if (game_over)  state_d = ST_OVER;
                else if (pause) state_d = ST_RUN;
            end
            ST_OVER: begin
                if (start) state_d = ST_RUN;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of the others.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= ST_IDLE;
        else      state_q <= state_d;
    end

    // -------------------------------------------------------------------------
    // Counter control
    // -------------------------------------------------------------------------
    // A fresh game starts from IDLE or OVER; resuming from PAUSE keeps counts.
    assign restart = ((state_q == ST_IDLE) || (state_q == ST_OVER)) && (state_d == ST_RUN);

    // Counters only move while RUN persists across the edge. The edge that
    // leaves RUN does not count, so a pause freezes the exact count shown and
    // no pulse can be registered into a non-RUN cycle.
    assign advance   = (state_q == ST_RUN) && (state_d == ST_RUN);
    assign sec_wrap  = advance && (sec_cnt_q == SEC_LAST);
    assign tick_wrap = advance && (tick_cnt_q == period_q - 32'd1);

    // -------------------------------------------------------------------------
    // Period target for the next tick
    // -------------------------------------------------------------------------
`ifdef SPEEDUP_EN
    localparam logic [31:0] STEP = 32'(TICK_STEP);
    localparam logic [31:0] MIN  = 32'(TICK_MIN);

    logic [31:0] step_x_sec;

    assign step_x_sec = STEP * {21'd0, sec_q};

    always_comb begin
        target = BASE - step_x_sec;
        if (step_x_sec >= BASE - MIN) target = MIN;
    end
`else
    assign target = BASE;
`endif

    // -------------------------------------------------------------------------
    // Datapath registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sec_cnt_q   <= '0;
            tick_cnt_q  <= '0;
            sec_q       <= '0;
            period_q    <= BASE;
            sec_tick_q  <= 1'b0;
            game_tick_q <= 1'b0;
        end else begin
            sec_tick_q  <= 1'b0;
            game_tick_q <= 1'b0;

            if (restart) begin
                // Target at sec = 0 is always TICK_BASE.
                sec_cnt_q  <= '0;
                tick_cnt_q <= '0;
                sec_q      <= '0;
                period_q   <= BASE;
            end else if (advance) begin
                if (sec_wrap) begin
                    sec_cnt_q <= '0;
                    if (sec_q != SEC_MAX) begin
                        sec_q      <= sec_q + 11'd1;
                        sec_tick_q <= 1'b1;
                    end
                end else begin
                    sec_cnt_q <= sec_cnt_q + 32'd1;
                end

                // The period only changes at a tick boundary, using the sec
                // value in force during the tick that is ending.
                if (tick_wrap) begin
                    tick_cnt_q  <= '0;
                    period_q    <= target;
                    game_tick_q <= 1'b1;
                end else begin
                    tick_cnt_q <= tick_cnt_q + 32'd1;
                end
            end
        end
    end

    assign state     = state_q;
    assign sec       = sec_q;
    assign sec_tick  = sec_tick_q;
    assign game_tick = game_tick_q;
    assign period    = period_q;

endmodule

// File: tb/tb_speed_scheduler.sv
// -----------------------------------------------------------------------------
// tb_speed_scheduler
//
// Bench for speed_scheduler with SEC_DIV=100, TICK_BASE=40, TICK_STEP=5,
// TICK_MIN=10. Expectations follow SPEEDUP_EN when the bench is compiled
// with it, and a fixed 40-cycle period otherwise.
// -----------------------------------------------------------------------------
module tb_speed_scheduler;

    localparam int SEC_DIV   = 100;
    localparam int TICK_BASE = 40;
    localparam int TICK_STEP = 5;
    localparam int TICK_MIN  = 10;
    localparam int RUN_LEN   = 2100;

`ifdef SPEEDUP_EN
    localparam bit SPEEDUP = 1'b1;
`else
    localparam bit SPEEDUP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic        pause = 1'b0;
    logic        game_over = 1'b0;
    logic [1:0]  state;
    logic [10:0] sec;
    logic        sec_tick;
    logic        game_tick;
    logic [31:0] period;

    int n_cmp  = 0;
    int n_fail = 0;

    speed_scheduler #(
        .SEC_DIV  (SEC_DIV),
        .TICK_BASE(TICK_BASE),
        .TICK_STEP(TICK_STEP),
        .TICK_MIN (TICK_MIN)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .pause    (pause),
        .game_over(game_over),
        .state    (state),
        .sec      (sec),
        .sec_tick (sec_tick),
        .game_tick(game_tick),
        .period   (period)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // One clock: drive requests before the edge, sample 1 time unit after it.
    task automatic step(input logic s, input logic p, input logic g);
        @(negedge clk);
        start     = s;
        pause     = p;
        game_over = g;
        @(posedge clk);
        #1;
        start     = 1'b0;
        pause     = 1'b0;
        game_over = 1'b0;
    endtask

    // Reference tick period for a given elapsed-seconds value.
    function automatic int tgt(input int s);
        if (!SPEEDUP) return TICK_BASE;
        if (TICK_STEP * s >= TICK_BASE - TICK_MIN) return TICK_MIN;
        return TICK_BASE - TICK_STEP * s;
    endfunction

    typedef struct {
        logic       s;
        logic       p;
        logic       g;
        logic [1:0] st;
    } vec_t;

    vec_t       vecs [17];
    logic [1:0] exp_state [$];
    int         exp_gt [$];
    int         exp_st [$];

    initial begin
        int  t;
        int  p;
        int  pulses;
        int  gap;
        bit  seen7;
        bit  seen10;
        bit  seen20;

        // ---------------- reset state ----------------
        #12;
        check("rst_state",     32'(state),     32'd0);
        check("rst_sec",       32'(sec),       32'd0);
        check("rst_period",    period,         32'd40);
        check("rst_game_tick", 32'(game_tick), 32'd0);
        check("rst_sec_tick",  32'(sec_tick),  32'd0);
        @(negedge clk);
        rst = 1'b1;

        // ---------------- FSM transition table ----------------
        //         start pause over  state
        vecs[0]  = '{1'b0, 1'b0, 1'b0, 2'd0};
        vecs[1]  = '{1'b0, 1'b1, 1'b0, 2'd0};
        vecs[2]  = '{1'b0, 1'b0, 1'b1, 2'd0};
        vecs[3]  = '{1'b1, 1'b0, 1'b0, 2'd1};
        vecs[4]  = '{1'b1, 1'b0, 1'b0, 2'd1};
        vecs[5]  = '{1'b0, 1'b1, 1'b0, 2'd2};
        vecs[6]  = '{1'b1, 1'b0, 1'b0, 2'd2};
        vecs[7]  = '{1'b0, 1'b0, 1'b0, 2'd2};
        vecs[8]  = '{1'b0, 1'b1, 1'b0, 2'd1};
        vecs[9]  = '{1'b1, 1'b1, 1'b0, 2'd2};
        vecs[10] = '{1'b0, 1'b1, 1'b1, 2'd3};
        vecs[11] = '{1'b0, 1'b1, 1'b0, 2'd3};
        vecs[12] = '{1'b0, 1'b0, 1'b1, 2'd3};
        vecs[13] = '{1'b1, 1'b0, 1'b0, 2'd1};
        vecs[14] = '{1'b1, 1'b1, 1'b1, 2'd3};
        vecs[15] = '{1'b1, 1'b0, 1'b0, 2'd1};
        vecs[16] = '{1'b0, 1'b0, 1'b1, 2'd3};

        for (int i = 0; i < 17; i++) begin
            exp_state.push_back(vecs[i].st);
            step(vecs[i].s, vecs[i].p, vecs[i].g);
            check($sformatf("fsm_row%0d", i), 32'(state), 32'(exp_state.pop_front()));
        end

        // ---------------- start + long run with speed-up ----------------
        step(1'b1, 1'b0, 1'b0);
        check("start_state",  32'(state), 32'd1);
        check("start_sec",    32'(sec),   32'd0);
        check("start_period", period,     32'd40);

        // Tick c means "pulse visible after the c-th edge since entering RUN".
        t = 0;
        p = tgt(0);
        forever begin
            t += p;
            if (t > RUN_LEN) break;
            exp_gt.push_back(t);
            p = tgt((t - 1) / SEC_DIV);
        end
        for (int k = SEC_DIV; k <= RUN_LEN; k += SEC_DIV) exp_st.push_back(k);

        seen7  = 1'b0;
        seen10 = 1'b0;
        seen20 = 1'b0;
        for (int c = 1; c <= RUN_LEN; c++) begin
            step(1'b0, 1'b0, 1'b0);
            if (game_tick) begin
                if (exp_gt.size() == 0) check("gt_extra", 32'(c), 32'd0);
                else                    check("gt_cycle", 32'(c), 32'(exp_gt.pop_front()));
            end
            if (sec_tick) begin
                if (exp_st.size() == 0) begin
                    check("st_extra", 32'(c), 32'd0);
                end else begin
                    check("st_cycle", 32'(c), 32'(exp_st.pop_front()));
                    check("st_sec", 32'(sec), 32'(c / SEC_DIV));
                end
            end
            if (sec == 11'd7 && !seen7) begin
                seen7 = 1'b1;
                check("period_sec7", period, SPEEDUP ? 32'd10 : 32'd40);
            end
            if (sec == 11'd10 && !seen10) begin
                seen10 = 1'b1;
                check("period_sec10", period, SPEEDUP ? 32'd10 : 32'd40);
            end
            if (sec == 11'd20 && !seen20) begin
                seen20 = 1'b1;
                check("period_sec20", period, SPEEDUP ? 32'd10 : 32'd40);
            end
        end
        check("gt_missing", 32'(exp_gt.size()), 32'd0);
        check("st_missing", 32'(exp_st.size()), 32'd0);
        check("run_sec_end", 32'(sec), 32'(RUN_LEN / SEC_DIV));

        // ---------------- pause at tick count 25 ----------------
        step(1'b0, 1'b0, 1'b1);
        check("over_state", 32'(state), 32'd3);
        step(1'b1, 1'b0, 1'b0);
        check("restart_state",  32'(state), 32'd1);
        check("restart_sec",    32'(sec),   32'd0);
        check("restart_period", period,     32'd40);

        pulses = 0;
        repeat (25) begin
            step(1'b0, 1'b0, 1'b0);
            if (game_tick || sec_tick) pulses++;
        end
        check("pre_pause_pulses", 32'(pulses), 32'd0);

        step(1'b0, 1'b1, 1'b0);
        check("pause_state", 32'(state), 32'd2);
        pulses = 0;
        repeat (500) begin
            step(1'b0, 1'b0, 1'b0);
            if (game_tick || sec_tick) pulses++;
        end
        check("paused_pulses", 32'(pulses), 32'd0);
        check("paused_state",  32'(state),  32'd2);
        check("paused_sec",    32'(sec),    32'd0);

        step(1'b0, 1'b1, 1'b0);
        check("resume_state", 32'(state), 32'd1);
        gap = 0;
        for (int i = 1; i <= 100; i++) begin
            step(1'b0, 1'b0, 1'b0);
            if (game_tick) begin
                gap = i;
                break;
            end
        end
        check("resume_gap", 32'(gap), 32'd15);

        // ---------------- game_over beats pause ----------------
        step(1'b0, 1'b1, 1'b1);
        check("prio_state", 32'(state), 32'd3);
        pulses = 0;
        repeat (60) begin
            step(1'b0, 1'b0, 1'b0);
            if (game_tick || sec_tick) pulses++;
        end
        check("over_pulses", 32'(pulses), 32'd0);
        step(1'b1, 1'b0, 1'b0);
        check("prio_restart_state",  32'(state), 32'd1);
        check("prio_restart_sec",    32'(sec),   32'd0);
        check("prio_restart_period", period,     32'd40);

        // ---------------- asynchronous reset mid-RUN ----------------
        repeat (130) step(1'b0, 1'b0, 1'b0);
        check("pre_reset_sec", 32'(sec), 32'd1);
        @(negedge clk);
        #2;
        rst = 1'b0;
        #1;
        check("async_rst_state",     32'(state),     32'd0);
        check("async_rst_sec",       32'(sec),       32'd0);
        check("async_rst_period",    period,         32'd40);
        check("async_rst_game_tick", 32'(game_tick), 32'd0);
        check("async_rst_sec_tick",  32'(sec_tick),  32'd0);
        @(negedge clk);
        rst = 1'b1;
        step(1'b0, 1'b0, 1'b0);
        check("post_rst_state", 32'(state), 32'd0);
        step(1'b1, 1'b0, 1'b0);
        check("post_rst_start", 32'(state), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
